// File: rtl/objects_mux_pkg.sv
// Shared types and constants for the object colour mux and its collision
// accumulator. The optional COLLISION_COORD_EN macro is consumed by the files
// that import this package; this file itself has no build options.
package objects_mux_pkg;

    // One VGA pixel colour, 3-3-2 RGB packed into a byte.
    typedef logic [7:0] rgb_t;

    // Objects report this colour on pixels they cover but do not paint.
    localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;

    // Collision accounting is only meaningful once a frame boundary has
    // been seen, so the block idles in WAIT_FRAME until the first one.
    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } mux_state_t;

endpackage

// File: rtl/objects_mux_collision_accumulator.sv
// Collision accumulator: gathers the set of colliding objects and the number
// of colliding pixels over one frame, and publishes them at the frame
// boundary. Build option COLLISION_COORD_EN additionally records the
// coordinate of the first colliding pixel of each frame.
module collision_accumulator
    import objects_mux_pkg::*;
#(
    parameter int NUM_OBJECTS = 4,
    parameter int COUNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frameStart_i,
    input  logic                   accumEn_i,
    input  logic                   publish_i,
    input  logic [NUM_OBJECTS-1:0] valid_i,
    input  logic                   collide_i,
`ifdef COLLISION_COORD_EN
    input  logic signed [10:0]     pixelX_i,
    input  logic signed [10:0]     pixelY_i,
    output logic signed [10:0]     collisionX_o,
    output logic signed [10:0]     collisionY_o,
`endif
    output logic [NUM_OBJECTS-1:0] mask_o,
    output logic [COUNT_W-1:0]     count_o,
    output logic                   pulse_o
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [NUM_OBJECTS-1:0] curMaskQ, curMaskD;
    logic [COUNT_W-1:0]     curCountQ, curCountD;
    logic [NUM_OBJECTS-1:0] maskQ;
    logic [COUNT_W-1:0]     countQ;
    logic                   pulseQ;

    // Frame accumulation: a frame boundary restarts the totals from this
    // cycle alone, so a collision on the start-of-frame pixel belongs to the
    // new frame; otherwise collisions OR into the mask and bump the count.
    always_comb begin
        curMaskD  = curMaskQ;
        curCountD = curCountQ;
        if (frameStart_i) begin
            curMaskD  = collide_i ? valid_i : '0;
            curCountD = collide_i ? COUNT_W'(1) : '0;
        end else if (accumEn_i && collide_i) begin
            curMaskD = curMaskQ | valid_i;
            if (curCountQ != COUNT_MAX) begin
                curCountD = curCountQ + COUNT_W'(1);
            end
        end
    end

    // Accumulator registers; reset throws away any partial frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            curMaskQ  <= '0;
            curCountQ <= '0;
        end else begin
            curMaskQ  <= curMaskD;
            curCountQ <= curCountD;
        end
    end

    // Published report: held between frames, the pulse lasts one cycle and
    // fires only when the finished frame saw at least one collision.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            maskQ  <= '0;
            countQ <= '0;
            pulseQ <= 1'b0;
        end else begin
            pulseQ <= 1'b0;
            if (publish_i) begin
                maskQ  <= curMaskQ;
                countQ <= curCountQ;
                pulseQ <= (curCountQ != '0);
            end
        end
    end

    assign mask_o  = maskQ;
    assign count_o = countQ;
    assign pulse_o = pulseQ;

`ifdef COLLISION_COORD_EN
    logic signed [10:0] firstXQ, firstXD;
    logic signed [10:0] firstYQ, firstYD;
    logic signed [10:0] reportXQ, reportYQ;

    // First-collision capture: a zero running count means nothing has been
    // captured yet this frame (the count saturates, never wraps to zero).
    always_comb begin
        firstXD = firstXQ;
        firstYD = firstYQ;
        if (frameStart_i) begin
            firstXD = collide_i ? pixelX_i : '0;
            firstYD = collide_i ? pixelY_i : '0;
        end else if (accumEn_i && collide_i && (curCountQ == '0)) begin
            firstXD = pixelX_i;
            firstYD = pixelY_i;
        end
    end

    // Coordinate capture and publish registers, updated alongside the mask.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            firstXQ  <= '0;
            firstYQ  <= '0;
            reportXQ <= '0;
            reportYQ <= '0;
        end else begin
            firstXQ <= firstXD;
            firstYQ <= firstYD;
            if (publish_i) begin
                reportXQ <= firstXQ;
                reportYQ <= firstYQ;
            end
        end
    end

    assign collisionX_o = reportXQ;
    assign collisionY_o = reportYQ;
`endif

endmodule

// File: rtl/objects_mux_collision.sv
// Object colour merger: picks the highest-priority painting object for each
// VGA pixel, registers the result, and reports per-frame object collisions.
// Build option COLLISION_COORD_EN adds collisionX/collisionY outputs holding
// the first colliding pixel of the previous frame.
module objects_mux_collision
    import objects_mux_pkg::*;
#(
    parameter int   NUM_OBJECTS      = 4,
    parameter rgb_t BACKGROUND_COLOR = 8'h00,
    parameter int   COUNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic signed [10:0]           PixelX,
    input  logic signed [10:0]           PixelY,
    input  logic [NUM_OBJECTS-1:0]       drawingRequest,
    input  rgb_t [NUM_OBJECTS-1:0]       RGBin,
    output rgb_t                         RGBout,
`ifdef COLLISION_COORD_EN
    output logic signed [10:0]           collisionX,
    output logic signed [10:0]           collisionY,
`endif
    output logic                         collisionPulse,
    output logic [NUM_OBJECTS-1:0]       collisionMask,
    output logic [COUNT_W-1:0]           collisionCount
);

    logic [NUM_OBJECTS-1:0] validVec;
    logic                   collide;
    rgb_t                   muxD, muxQ;
    mux_state_t             stateQ, stateD;
    logic                   accumEn;
    logic                   publish;

    // An object only counts as drawing if it is not painting transparency.
    always_comb begin
        validVec = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            validVec[i] = drawingRequest[i] && (RGBin[i] != TRANSPARENT_ENCODING);
        end
    end

    // Clearing the lowest set bit leaves something only when two or more
    // objects are valid, which is exactly a collision pixel.
    assign collide = |(validVec & (validVec - NUM_OBJECTS'(1)));

    // Priority mux: scan from the lowest priority upward so the lowest
    // valid index is the last to write and therefore wins.
    always_comb begin
        muxD = BACKGROUND_COLOR;
        for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
            if (validVec[i]) begin
                muxD = RGBin[i];
            end
        end
    end

    // Output colour register, one pixel of latency.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            muxQ <= BACKGROUND_COLOR;
        end else begin
            muxQ <= muxD;
        end
    end

    assign RGBout = muxQ;

    // Frame state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ <= WAIT_FRAME;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state and accumulator controls: nothing is published until a
    // full frame has been observed after reset.
    always_comb begin
        stateD  = stateQ;
        accumEn = 1'b0;
        publish = 1'b0;
        case (stateQ)
            WAIT_FRAME: begin
                if (startOfFrame) begin
                    stateD = ACTIVE;
                end
            end
            ACTIVE: begin
                accumEn = 1'b1;
                publish = startOfFrame;
            end
            default: begin
                stateD = WAIT_FRAME;
            end
        endcase
    end

`ifndef COLLISION_COORD_EN
    logic unusedPixel;
    assign unusedPixel = ^{PixelX, PixelY};
`endif

    collision_accumulator #(
        .NUM_OBJECTS (NUM_OBJECTS),
        .COUNT_W     (COUNT_W)
    ) u_accumulator (
        .clk          (clk),
        .resetN       (resetN),
        .frameStart_i (startOfFrame),
        .accumEn_i    (accumEn),
        .publish_i    (publish),
        .valid_i      (validVec),
        .collide_i    (collide),
`ifdef COLLISION_COORD_EN
        .pixelX_i     (PixelX),
        .pixelY_i     (PixelY),
        .collisionX_o (collisionX),
        .collisionY_o (collisionY),
`endif
        .mask_o       (collisionMask),
        .count_o      (collisionCount),
        .pulse_o      (collisionPulse)
    );

endmodule

// File: tb/tb_objects_mux_collision.sv
// Testbench for objects_mux_collision (default build, COLLISION_COORD_EN
// undefined): directed scenarios plus randomized frames, compared every
// cycle against a frame-level reference model.
module tb_objects_mux_collision;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic signed [10:0] PixelX;
    logic signed [10:0] PixelY;
    logic [3:0]        drawingRequest;
    logic [3:0][7:0]   RGBin;
    logic [7:0]        RGBout;
    logic              collisionPulse;
    logic [3:0]        collisionMask;
    logic [15:0]       collisionCount;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit mActive;
    int mCurMask, mCurCount;
    int mMask, mCount, mPulse, mRgb;

    objects_mux_collision #(
        .NUM_OBJECTS      (4),
        .BACKGROUND_COLOR (8'h00),
        .COUNT_W          (16)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .PixelX         (PixelX),
        .PixelY         (PixelY),
        .drawingRequest (drawingRequest),
        .RGBin          (RGBin),
        .RGBout         (RGBout),
        .collisionPulse (collisionPulse),
        .collisionMask  (collisionMask),
        .collisionCount (collisionCount)
    );

    // 100 MHz pixel clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mActive   = 1'b0;
        mCurMask  = 0;
        mCurCount = 0;
        mMask     = 0;
        mCount    = 0;
        mPulse    = 0;
        mRgb      = 0;
    endtask

    // One clock of the reference behaviour, from the frame-level rules
    task automatic modelClock(input logic sof, input logic [3:0] dr, input logic [3:0][7:0] rgb);
        int nValid = 0;
        int vMask = 0;
        bit found = 0;
        bit collide;
        mRgb = 0;
        for (int i = 0; i < 4; i++) begin
            if (dr[i] && rgb[i] != 8'hFF) begin
                nValid++;
                vMask = vMask | (1 << i);
                if (!found) begin
                    mRgb = rgb[i];
                    found = 1;
                end
            end
        end
        collide = (nValid >= 2);
        mPulse = 0;
        if (mActive && sof) begin
            mMask  = mCurMask;
            mCount = mCurCount;
            mPulse = (mCurCount != 0);
        end
        if (sof) begin
            mCurMask  = collide ? vMask : 0;
            mCurCount = collide ? 1 : 0;
            mActive   = 1'b1;
        end else if (mActive && collide) begin
            mCurMask = mCurMask | vMask;
            if (mCurCount < 65535) mCurCount++;
        end
    endtask

    task automatic checkAll();
        checkOutput("RGBout", {24'h0, RGBout}, mRgb);
        checkOutput("collisionPulse", {31'h0, collisionPulse}, mPulse);
        checkOutput("collisionMask", {28'h0, collisionMask}, mMask);
        checkOutput("collisionCount", {16'h0, collisionCount}, mCount);
    endtask

    // Drive one pixel, clock it, then compare #1 after the edge
    task automatic applyStimulus(input logic sof, input logic [3:0] dr, input logic [3:0][7:0] rgb);
        startOfFrame   = sof;
        drawingRequest = dr;
        RGBin          = rgb;
        PixelX         = 11'($urandom_range(0, 799));
        PixelY         = 11'($urandom_range(0, 524));
        @(posedge clk);
        modelClock(sof, dr, rgb);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        startOfFrame   = 1'b0;
        drawingRequest = '0;
        RGBin          = '0;
        resetN         = 1'b0;
        #2;
        modelReset();
        checkAll();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll();
        resetN = 1'b1;
    endtask

    function automatic logic [7:0] randColor();
        if ($urandom_range(0, 3) == 0) return 8'hFF;
        return 8'($urandom_range(0, 254));
    endfunction

    initial begin
        logic [3:0][7:0] rgb;
        PixelX = '0;
        PixelY = '0;
        #1;
        doReset();

        // First pulse leaves WAIT_FRAME, then object 1 alone
        applyStimulus(1'b1, 4'b0000, '0);
        rgb = '0;
        rgb[1] = 8'h1C;
        applyStimulus(1'b0, 4'b0010, rgb);
        checkOutput("soloColor", {24'h0, RGBout}, 32'h1C);
        applyStimulus(1'b0, 4'b0010, rgb);
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("soloNoPulse", {31'h0, collisionPulse}, 32'h0);

        // Objects 0 and 2 overlap for 5 pixels
        rgb = '0;
        rgb[0] = 8'hE0;
        rgb[2] = 8'h03;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0101, rgb);
            checkOutput("overlapColor", {24'h0, RGBout}, 32'hE0);
        end
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("overlapPulse", {31'h0, collisionPulse}, 32'h1);
        checkOutput("overlapMask", {28'h0, collisionMask}, 32'h5);
        checkOutput("overlapCount", {16'h0, collisionCount}, 32'h5);
        applyStimulus(1'b0, 4'b0000, '0);
        checkOutput("pulseOneCycle", {31'h0, collisionPulse}, 32'h0);
        checkOutput("maskHeld", {28'h0, collisionMask}, 32'h5);

        // Transparent object 0 does not block or collide with object 3
        rgb = '0;
        rgb[0] = 8'hFF;
        rgb[3] = 8'h40;
        applyStimulus(1'b0, 4'b1001, rgb);
        checkOutput("transparentColor", {24'h0, RGBout}, 32'h40);
        applyStimulus(1'b0, 4'b1001, rgb);

        // Collision on the start-of-frame pixel belongs to the new frame
        rgb = '0;
        rgb[0] = 8'hE0;
        rgb[2] = 8'h03;
        applyStimulus(1'b1, 4'b0101, rgb);
        checkOutput("sofCollideCount", {16'h0, collisionCount}, 32'h0);
        applyStimulus(1'b0, 4'b0000, '0);
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("sofCarryCount", {16'h0, collisionCount}, 32'h1);
        checkOutput("sofCarryPulse", {31'h0, collisionPulse}, 32'h1);

        // Randomized frames, including back-to-back boundaries
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(0, 30);
            for (int k = 0; k < 4; k++) rgb[k] = randColor();
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), rgb);
            for (int c = 0; c < len; c++) begin
                for (int k = 0; k < 4; k++) rgb[k] = randColor();
                applyStimulus(1'b0, 4'($urandom_range(0, 15)), rgb);
            end
        end

        // Saturation: 70000 colliding pixels in one frame
        applyStimulus(1'b1, 4'b0000, '0);
        rgb = '0;
        rgb[1] = 8'h11;
        rgb[3] = 8'h33;
        for (int c = 0; c < 70000; c++) begin
            applyStimulus(1'b0, 4'b1010, rgb);
        end
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("satCount", {16'h0, collisionCount}, 32'hFFFF);
        checkOutput("satMask", {28'h0, collisionMask}, 32'hA);

        // Reset in the middle of a colliding frame
        applyStimulus(1'b1, 4'b0000, '0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1010, rgb);
        end
        doReset();
        checkOutput("resetCount", {16'h0, collisionCount}, 32'h0);
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("postResetPulse", {31'h0, collisionPulse}, 32'h0);
        checkOutput("postResetCount", {16'h0, collisionCount}, 32'h0);
        applyStimulus(1'b0, 4'b1010, rgb);
        applyStimulus(1'b1, 4'b0000, '0);
        checkOutput("afterResetFrame", {16'h0, collisionCount}, 32'h1);
        applyStimulus(1'b0, 4'b0000, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
